if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage of the segmented (hazard-aware) pipeline. It is the writer side of the IF/ID pipeline register.
- Keeps the PC and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Presents PC_IF/idata_IF/VALID_IF to IF/ID.
- Takes STALL from the hazard unit and REDIRECT (taken branch/jump) from EX.
- Guarantees no instruction is lost or duplicated across stalls, and wrong-path instructions are killed.

Parameters:
size, 32, datapath/PC width
RESET_PC, 32'h00000000, first fetch address after reset
NOP, 32'h00000013, bubble encoding (addi x0,x0,0) driven on idata_IF when VALID_IF=0

Ports:
CLK  in  1  clock
RESET_N  in  1  reset
STALL  in  1  hazard unit: IF/ID not loading this cycle; hold current instruction
REDIRECT  in  1  EX: control-flow change; current IF content is wrong-path
REDIRECT_PC  in  size  redirect target; bits [1:0] ignored (treated as 0)
iaddr  out  size  instruction memory address (combinational)
ireq  out  1  instruction memory read enable
idata_mem  in  size  memory read data, valid exactly 1 cycle after ireq=1
PC_IF  out  size  PC of presented instruction
idata_IF  out  size  presented instruction word
VALID_IF  out  1  presented instruction is real (not bubble)

Behaviour:
- Reset: RESET_N, asynchronous, active-low; clock CLK. While RESET_N=0:
  - PC_IF=0, idata_IF=NOP, VALID_IF=0, ireq=0, iaddr=RESET_PC.
  - State BOOT; resp_valid=0, hold_valid=0; any in-flight response discarded.
- Internal registers:
  - pc_req: next address to request.
  - pc_resp / resp_valid: request whose data arrives this cycle.
  - hold_pc / hold_data / hold_valid: skid buffer.
- States: BOOT, RUN, HOLD.
- BOOT (first cycle after reset release):
  - ireq=1, iaddr=RESET_PC, VALID_IF=0.
  - Next: RUN, pc_resp=RESET_PC, resp_valid=1, pc_req=RESET_PC+4.
- RUN:
  - Output mux: PC_IF=pc_resp, idata_IF=idata_mem, VALID_IF=resp_valid. When resp_valid=0: idata_IF=NOP.
  - ireq=!STALL, iaddr=pc_req.
  - On ireq: pc_req+=4, next pc_resp=pc_req, next resp_valid=1. Otherwise next resp_valid=0.
  - STALL=1 with resp_valid=1: capture hold_pc=pc_resp, hold_data=idata_mem, hold_valid=1; go HOLD.
  - STALL=1 with resp_valid=0: stay RUN, nothing captured.
- HOLD:
  - Outputs come from the hold buffer, VALID_IF=1, stable every cycle.
  - While STALL=1: ireq=0, pc_req unchanged.
  - STALL=0 cycle:
    - Hold buffer still presented (IF/ID consumes it).
    - ireq=1, iaddr=pc_req, pc_req+=4.
    - Next: RUN, resp_valid=1, hold_valid=0.
  - Resulting stream has no bubble and no duplicate.
- REDIRECT (any state except BOOT; priority over STALL):
  - Same cycle: VALID_IF=0, idata_IF=NOP, ireq=1, iaddr={REDIRECT_PC[size-1:2],2'b00}.
  - Next cycle: pc_resp=that address, resp_valid=1, pc_req=address+4, hold_valid=0, state RUN.
  - STALL high in the next cycle follows the normal RUN stall rule (capture into HOLD).
- REDIRECT during BOOT: ignored.
- Arithmetic: PC increment modulo 2^size; 0xFFFFFFFC+4 → 0x00000000, no flag.
- idata_mem is sampled only when resp_valid=1; otherwise don't-care.
- Outputs never go X after reset.

Test Plan:
1. Reset release; memory returns word = address ^ 32'hA5A50000. Required sequence:
   - Cycle 1: ireq=1, iaddr=0, VALID_IF=0.
   - Cycle 2: PC_IF=0, idata_IF=A5A50000, VALID_IF=1.
   - Cycle 3: PC_IF=4, VALID_IF=1.
2. STALL=1 for 3 cycles while PC_IF=8 presented:
   - PC_IF=8 and idata_IF=A5A50008 constant for all 3 cycles, plus the release cycle.
   - ireq=0 during the stall.
   - Cycle after release: PC_IF=0xC, VALID_IF=1; no gap, no repeat of 8.
3. REDIRECT=1, REDIRECT_PC=0x102, while PC_IF=0x10:
   - Same cycle: VALID_IF=0, idata_IF=0x00000013, iaddr=0x100.
   - Next cycles: PC_IF=0x100, then 0x104, both valid.
4. REDIRECT and STALL both high in the same cycle while in HOLD:
   - Hold buffer cleared.
   - Next cycle, with STALL still 1: PC_IF=0x100 valid, captured into HOLD.
   - After STALL drops: 0x104 follows.
5. REDIRECT_PC=0xFFFFFFFC, no stalls → PC_IF=0xFFFFFFFC, then 0x00000000, then 0x00000004, all valid.
6. RESET_N pulsed low mid-HOLD, asynchronously between edges:
   - Immediately: PC_IF=0, idata_IF=NOP, VALID_IF=0, ireq=0.
   - After release: BOOT, then PC_IF=RESET_PC; old hold data never appears.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory, feeds IF/ID.
// Latency: a fetched word is presented the cycle after its request; redirect kills the current slot in the same cycle.
// Backpressure: STALL freezes the presented word in a one-entry skip buffer and suppresses new requests.
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   STALL                 IF/ID not loading this cycle
//   REDIRECT, REDIRECT_PC control-flow change from EX and its target (bits [1:0] ignored)
//   iaddr, ireq           instruction memory address / read enable
//   idata_mem             memory read data, one cycle after ireq
//   PC_IF, idata_IF       presented instruction PC and word (NOP when not valid)
//   VALID_IF              presented instruction is real
module if_fetch_unit #(
  parameter int              size     = 32,
  parameter logic [size-1:0] RESET_PC = '0,
  parameter logic [size-1:0] NOP      = size'(32'h00000013)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            STALL,
  input  logic            REDIRECT,
  input  logic [size-1:0] REDIRECT_PC,
  output logic [size-1:0] iaddr,
  output logic            ireq,
  input  logic [size-1:0] idata_mem,
  output logic [size-1:0] PC_IF,
  output logic [size-1:0] idata_IF,
  output logic            VALID_IF
);

  localparam logic [size-1:0] PC_STEP = size'(4);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [size-1:0] pc_req_q, pc_req_d;
  logic [size-1:0] pc_resp_q, pc_resp_d;
  logic            resp_valid_q, resp_valid_d;
  logic [size-1:0] hold_pc_q, hold_pc_d;
  logic [size-1:0] hold_data_q, hold_data_d;
  logic            hold_valid_q, hold_valid_d;

  logic            req_en;
  logic [size-1:0] req_addr;
  logic [size-1:0] out_pc;
  logic [size-1:0] out_dat;
  logic            out_vld;

  logic [size-1:0] redir_addr;
  logic            redir_take;
  logic            redir_lsb_unused;

  // Targets are word aligned; the low two bits of the redirect target carry no information.
  assign redir_addr       = {REDIRECT_PC[size-1:2], 2'b00};
  assign redir_lsb_unused = ^REDIRECT_PC[1:0];
  // The boot request is already in flight to RESET_PC, so a redirect there is dropped.
  assign redir_take       = REDIRECT && (state_q != ST_BOOT);

  always_comb begin
    state_d      = state_q;
    pc_req_d     = pc_req_q;
    pc_resp_d    = pc_resp_q;
    // A response is only expected the cycle after a request was actually issued.
    resp_valid_d = 1'b0;
    hold_pc_d    = hold_pc_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    req_en       = 1'b0;
    req_addr     = pc_req_q;
    out_pc       = '0;
    out_dat      = NOP;
    out_vld      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        req_en       = 1'b1;
        req_addr     = RESET_PC;
        state_d      = ST_RUN;
        pc_resp_d    = RESET_PC;
        resp_valid_d = 1'b1;
        pc_req_d     = RESET_PC + PC_STEP;
      end

      ST_RUN: begin
        out_pc  = pc_resp_q;
        out_vld = resp_valid_q;
        out_dat = resp_valid_q ? idata_mem : NOP;
        req_en  = !STALL;
        if (req_en) begin
          pc_req_d     = pc_req_q + PC_STEP;
          pc_resp_d    = pc_req_q;
          resp_valid_d = 1'b1;
        end
        // Memory data is only on the bus this one cycle, so a stalled real
        // instruction must be parked or it would be lost.
        if (STALL && resp_valid_q) begin
          hold_pc_d    = pc_resp_q;
          hold_data_d  = idata_mem;
          hold_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end

      ST_HOLD: begin
        out_pc  = hold_pc_q;
        out_dat = hold_data_q;
        out_vld = hold_valid_q;
        // On release the held word is consumed this cycle while the next
        // request goes out, so its data lands right behind without a gap.
        if (!STALL) begin
          req_en       = 1'b1;
          pc_req_d     = pc_req_q + PC_STEP;
          pc_resp_d    = pc_req_q;
          resp_valid_d = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Redirect wins over stall: whatever is presented now is wrong-path.
    if (redir_take) begin
      out_vld      = 1'b0;
      out_dat      = NOP;
      req_en       = 1'b1;
      req_addr     = redir_addr;
      pc_resp_d    = redir_addr;
      resp_valid_d = 1'b1;
      pc_req_d     = redir_addr + PC_STEP;
      hold_valid_d = 1'b0;
      state_d      = ST_RUN;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_BOOT;
      pc_req_q     <= RESET_PC;
      pc_resp_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_data_q  <= NOP;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_req_q     <= pc_req_d;
      pc_resp_q    <= pc_resp_d;
      resp_valid_q <= resp_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  // The reset state equals the boot state except that no request may leave
  // the block while reset is asserted.
  assign ireq     = req_en && RESET_N;
  assign iaddr    = req_addr;
  assign PC_IF    = out_pc;
  assign idata_IF = out_dat;
  assign VALID_IF = out_vld;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed sequences plus a random stall/redirect phase.
// Memory returns address ^ A5A50000 one cycle after each request.
// Every instruction loaded into IF/ID is checked against an in-order expected-PC queue.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] XK  = 32'hA5A50000;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic [31:0] iaddr;
  logic        ireq;
  logic [31:0] idata_mem = '0;
  logic [31:0] PC_IF;
  logic [31:0] idata_IF;
  logic        VALID_IF;

  always #5 CLK = ~CLK;

  if_fetch_unit #(
    .size    (32),
    .RESET_PC(32'h00000000),
    .NOP     (NOP)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .STALL      (STALL),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .iaddr      (iaddr),
    .ireq       (ireq),
    .idata_mem  (idata_mem),
    .PC_IF      (PC_IF),
    .idata_IF   (idata_IF),
    .VALID_IF   (VALID_IF)
  );

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge CLK) begin
    if (ireq) idata_mem <= iaddr ^ XK;
  end

  int          n_chk = 0;
  int          n_err = 0;
  int          n_cons = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  logic [31:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Start a fresh expected program-order stream at pc (flushes wrong-path entries).
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(pc + 32'(4 * k));
    exp_tail = pc + 32'd12;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // An instruction is loaded into IF/ID when it is valid and not stalled.
  always @(negedge CLK) begin
    if (mon_en && RESET_N && VALID_IF && !STALL) begin
      chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", PC_IF, mon_e);
        chk("sb_dat", idata_IF, mon_e ^ XK);
        exp_tail = exp_tail + 32'd4;
        exp_q.push_back(exp_tail);
        n_cons++;
      end
    end
  end

  initial begin
    int          cons_start;
    logic [31:0] rpc;

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_pc", PC_IF, 32'h0);
    chk("rst_dat", idata_IF, NOP);
    chk("rst_vld", 32'(VALID_IF), 32'd0);
    chk("rst_ireq", 32'(ireq), 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);

    // Boot sequence
    sb_restart(32'h0);
    mon_en = 1'b1;
    RESET_N = 1'b1;
    #1;
    chk("boot_ireq", 32'(ireq), 32'd1);
    chk("boot_iaddr", iaddr, 32'h0);
    chk("boot_vld", 32'(VALID_IF), 32'd0);
    cyc(); #1;
    chk("c2_pc", PC_IF, 32'h0);
    chk("c2_dat", idata_IF, 32'hA5A50000);
    chk("c2_vld", 32'(VALID_IF), 32'd1);
    cyc(); #1;
    chk("c3_pc", PC_IF, 32'h4);
    chk("c3_vld", 32'(VALID_IF), 32'd1);
    cyc(); #1;
    chk("c4_pc", PC_IF, 32'h8);

    // Three stall cycles while 8 is presented
    STALL = 1'b1;
    #1;
    chk("stl0_ireq", 32'(ireq), 32'd0);
    chk("stl0_dat", idata_IF, 32'hA5A50008);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("stl_pc", PC_IF, 32'h8);
      chk("stl_dat", idata_IF, 32'hA5A50008);
      chk("stl_vld", 32'(VALID_IF), 32'd1);
      chk("stl_ireq", 32'(ireq), 32'd0);
    end
    cyc();
    STALL = 1'b0;
    #1;
    chk("rel_pc", PC_IF, 32'h8);
    chk("rel_dat", idata_IF, 32'hA5A50008);
    chk("rel_ireq", 32'(ireq), 32'd1);
    chk("rel_iaddr", iaddr, 32'hC);
    cyc(); #1;
    chk("nxt_pc", PC_IF, 32'hC);
    chk("nxt_vld", 32'(VALID_IF), 32'd1);
    cyc(); #1;
    chk("pre_rd_pc", PC_IF, 32'h10);

    // Redirect to 0x102 (aligned to 0x100)
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h102;
    sb_restart(32'h100);
    #1;
    chk("rd_vld", 32'(VALID_IF), 32'd0);
    chk("rd_dat", idata_IF, NOP);
    chk("rd_iaddr", iaddr, 32'h100);
    chk("rd_ireq", 32'(ireq), 32'd1);
    cyc();
    REDIRECT = 1'b0;
    #1;
    chk("rd1_pc", PC_IF, 32'h100);
    chk("rd1_vld", 32'(VALID_IF), 32'd1);
    chk("rd1_dat", idata_IF, 32'h100 ^ XK);
    cyc(); #1;
    chk("rd2_pc", PC_IF, 32'h104);
    chk("rd2_vld", 32'(VALID_IF), 32'd1);

    // Enter HOLD with 0x104, then redirect and stall together
    STALL = 1'b1;
    cyc(); #1;
    chk("hold_pc", PC_IF, 32'h104);
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h100;
    sb_restart(32'h100);
    #1;
    chk("rs_vld", 32'(VALID_IF), 32'd0);
    chk("rs_ireq", 32'(ireq), 32'd1);
    chk("rs_iaddr", iaddr, 32'h100);
    cyc();
    REDIRECT = 1'b0;
    #1;
    chk("rs1_pc", PC_IF, 32'h100);
    chk("rs1_vld", 32'(VALID_IF), 32'd1);
    chk("rs1_ireq", 32'(ireq), 32'd0);
    cyc(); #1;
    chk("rs2_pc", PC_IF, 32'h100);
    chk("rs2_dat", idata_IF, 32'h100 ^ XK);
    cyc();
    STALL = 1'b0;
    #1;
    chk("rs3_pc", PC_IF, 32'h100);
    chk("rs3_ireq", 32'(ireq), 32'd1);
    chk("rs3_iaddr", iaddr, 32'h104);
    cyc(); #1;
    chk("rs4_pc", PC_IF, 32'h104);
    chk("rs4_vld", 32'(VALID_IF), 32'd1);

    // Wraparound at the top of the address space
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'hFFFFFFFC;
    sb_restart(32'hFFFFFFFC);
    #1;
    chk("wr_iaddr", iaddr, 32'hFFFFFFFC);
    cyc();
    REDIRECT = 1'b0;
    #1;
    chk("wr1_pc", PC_IF, 32'hFFFFFFFC);
    chk("wr1_vld", 32'(VALID_IF), 32'd1);
    cyc(); #1;
    chk("wr2_pc", PC_IF, 32'h0);
    chk("wr2_vld", 32'(VALID_IF), 32'd1);
    cyc(); #1;
    chk("wr3_pc", PC_IF, 32'h4);
    chk("wr3_vld", 32'(VALID_IF), 32'd1);

    // Asynchronous reset in the middle of HOLD
    STALL = 1'b1;
    cyc(); #1;
    chk("h6_pc", PC_IF, 32'h4);
    cyc(); #2;
    RESET_N = 1'b0;
    #1;
    chk("ar_pc", PC_IF, 32'h0);
    chk("ar_dat", idata_IF, NOP);
    chk("ar_vld", 32'(VALID_IF), 32'd0);
    chk("ar_ireq", 32'(ireq), 32'd0);
    chk("ar_iaddr", iaddr, 32'h0);
    STALL = 1'b0;
    cyc();
    cyc(); #2;
    sb_restart(32'h0);
    RESET_N = 1'b1;
    #1;
    chk("b6_vld", 32'(VALID_IF), 32'd0);
    chk("b6_ireq", 32'(ireq), 32'd1);
    cyc(); #1;
    chk("b6_pc", PC_IF, 32'h0);
    chk("b6_dat", idata_IF, 32'hA5A50000);
    cyc(); #1;
    chk("b6_pc2", PC_IF, 32'h4);

    // Random stalls and redirects, checked by the scoreboard
    cons_start = n_cons;
    for (int i = 0; i < 300; i++) begin
      cyc();
      STALL = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) begin
        rpc = $urandom;
        REDIRECT = 1'b1;
        REDIRECT_PC = rpc;
        sb_restart({rpc[31:2], 2'b00});
      end else begin
        REDIRECT = 1'b0;
      end
    end
    cyc();
    REDIRECT = 1'b0;
    STALL = 1'b0;
    repeat (3) cyc();
    chk("rand_progress", 32'((n_cons - cons_start) > 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
